// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the LSTM activation path: default widths,
// the sigmoid lookup table and the Q-format typedefs used around it.
package nn_fixed_pkg;

  localparam int NN_DATA_WIDTH   = 8;
  localparam int NN_ADDR_WIDTH   = 4;
  localparam int LUT_DEPTH       = 16;
  localparam int LUT_ENTRY_WIDTH = 8;

  typedef logic [LUT_ENTRY_WIDTH-1:0] lut_entry_t;

  // Q3.4 pre-activation in, sigmoid scaled by 16 out (0..15).
  typedef logic signed [NN_DATA_WIDTH-1:0] q3_4_t;
  typedef logic        [NN_DATA_WIDTH-1:0] q0_4_t;
  typedef logic        [NN_ADDR_WIDTH-1:0] lut_addr_t;

  // Indexed by the two's-complement bucket: 0..7 cover x >= 0, 8..15 cover x < 0.
  localparam lut_entry_t SIGMOID_LUT [LUT_DEPTH] = '{
    8'd8,  8'd11, 8'd14, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15,
    8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd1,  8'd4
  };

endpackage

// File: rtl/sigmoid_lut.sv
// Combinational sigmoid table read: returns the entry for the bucket and the
// entry of the next-higher bucket in value order. Bucket -1 (all ones) steps
// up to bucket 0; the most positive bucket has no successor and repeats itself.
module sigmoid_lut
  import nn_fixed_pkg::*;
#(
  parameter int DATA_WIDTH = NN_DATA_WIDTH,
  parameter int ADDR_WIDTH = NN_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] base,
  output logic [DATA_WIDTH-1:0] next_data
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP_POS = {1'b0, {(ADDR_WIDTH-1){1'b1}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_NEG_ONE = '1;

  logic [ADDR_WIDTH-1:0] next_addr;

  // Pick the neighbour bucket: wrap -1 -> 0, saturate at the top positive bucket.
  always_comb begin
    next_addr = addr + ADDR_WIDTH'(1);
    if (addr == ADDR_NEG_ONE) begin
      next_addr = '0;
    end else if (addr == ADDR_TOP_POS) begin
      next_addr = addr;
    end
  end

  // Table lookups for both interpolation endpoints.
  always_comb begin
    base      = DATA_WIDTH'(SIGMOID_LUT[addr]);
    next_data = DATA_WIDTH'(SIGMOID_LUT[next_addr]);
  end

endmodule

// File: rtl/sigmoid_lut_interpolator.sv
// Sigmoid activation for the LSTM gates: addresses the LUT with the upper bits
// of the pre-activation and linearly interpolates with the lower bits.
// Two-stage valid/ready pipeline with full backpressure.
//
// Pipeline occupancy is carried by the two valid bits only:
//   state   | meaning
//   empty   | s1_valid=0, out_valid=0: nothing in flight
//   s1      | s1_valid=1, out_valid=0: LUT pair captured, result next edge
//   s2      | s1_valid=0, out_valid=1: result presented, stage 1 free
//   s1+s2   | s1_valid=1, out_valid=1: full; in_ready follows out_ready
module sigmoid_lut_interpolator
  import nn_fixed_pkg::*;
#(
  parameter int DATA_WIDTH = NN_DATA_WIDTH,
  parameter int ADDR_WIDTH = NN_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_y
);

  localparam int FRAC_WIDTH = DATA_WIDTH - ADDR_WIDTH;
  localparam int DIFF_WIDTH = DATA_WIDTH + 1;
  // Signed diff times (frac with a zero sign bit) fits exactly in this width.
  localparam int PROD_WIDTH = DIFF_WIDTH + FRAC_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] lut_addr;
  logic [FRAC_WIDTH-1:0] in_frac;
  logic [DATA_WIDTH-1:0] lut_base;
  logic [DATA_WIDTH-1:0] lut_next;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_base;
  logic [DATA_WIDTH-1:0] s1_next;
  logic [FRAC_WIDTH-1:0] s1_frac;

  logic s2_adv;
  logic s1_adv;
  logic accept;

  logic signed [DIFF_WIDTH-1:0] diff;
  logic signed [PROD_WIDTH-1:0] prod;
  logic        [DATA_WIDTH-1:0] y;

  assign lut_addr = in_x[DATA_WIDTH-1 -: ADDR_WIDTH];
  assign in_frac  = in_x[FRAC_WIDTH-1:0];

  sigmoid_lut #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_lut (
    .addr      (lut_addr),
    .base      (lut_base),
    .next_data (lut_next)
  );

  // Handshake: stage 2 moves when empty or drained; in_ready never looks at in_valid.
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = s1_valid && s2_adv;
    in_ready = !s1_valid || s2_adv;
    accept   = in_valid && in_ready;
  end

  // Interpolation: base + floor((next - base) * frac / 2^FRAC_WIDTH).
  // The result lies between base and next, so truncation to DATA_WIDTH is exact.
  always_comb begin
    diff = DIFF_WIDTH'($signed(s1_next)) - DIFF_WIDTH'($signed(s1_base));
    prod = PROD_WIDTH'(diff) * PROD_WIDTH'($signed({1'b0, s1_frac}));
    y    = s1_base + DATA_WIDTH'(prod >>> FRAC_WIDTH);
  end

  // Stage 1: capture the LUT pair and fraction on accept, empty when advanced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_base  <= '0;
      s1_next  <= '0;
      s1_frac  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_base  <= lut_base;
      s1_next  <= lut_next;
      s1_frac  <= in_frac;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register, held stable while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y <= y;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_lut_interpolator.sv
// Directed and randomized checks for sigmoid_lut_interpolator.
module tb_sigmoid_lut_interpolator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;

  int n_tests;
  int n_fail;

  sigmoid_lut_interpolator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
  } vec_t;

  localparam int NVEC  = 20;
  localparam int NRAND = 10000;

  vec_t vecs [NVEC];

  int ref_lut [16] = '{8, 11, 14, 15, 15, 15, 15, 15, 0, 0, 0, 0, 0, 0, 1, 4};

  function automatic int model(input logic [7:0] x);
    int a, f, nx, b, n, d;
    a  = int'(x[7:4]);
    f  = int'(x[3:0]);
    nx = (a == 15) ? 0 : ((a == 7) ? 7 : a + 1);
    b  = ref_lut[a];
    n  = ref_lut[nx];
    d  = (n - b) * f;
    return b + (d >>> 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  initial begin
    int lat;
    int cyc;
    int sent;
    int got;
    bit acc;
    bit prev_stall;
    logic [7:0] prev_y;
    logic [7:0] e;

    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{8'h00, 8'd8};
    vecs[1]  = '{8'h08, 8'd9};
    vecs[2]  = '{8'hF8, 8'd6};
    vecs[3]  = '{8'hE8, 8'd2};
    vecs[4]  = '{8'h7F, 8'd15};
    vecs[5]  = '{8'h80, 8'd0};
    vecs[6]  = '{8'h04, 8'd8};
    vecs[7]  = '{8'h0C, 8'd10};
    vecs[8]  = '{8'h10, 8'd11};
    vecs[9]  = '{8'h18, 8'd12};
    vecs[10] = '{8'h2F, 8'd14};
    vecs[11] = '{8'h3F, 8'd15};
    vecs[12] = '{8'hFF, 8'd7};
    vecs[13] = '{8'hD0, 8'd0};
    vecs[14] = '{8'hDF, 8'd0};
    vecs[15] = '{8'hE0, 8'd1};
    vecs[16] = '{8'hEF, 8'd3};
    vecs[17] = '{8'hF0, 8'd4};
    vecs[18] = '{8'h70, 8'd15};
    vecs[19] = '{8'h8F, 8'd0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = 8'h00;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Table-driven single samples with out_ready held high.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_x      = vecs[i].x;
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_x%02h_y", i, vecs[i].x), 32'(out_y), 32'(vecs[i].y));
    end
    @(negedge clk);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: 0x00, 0x08, 0xF8 back-to-back, stall 3 cycles after first result.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_x      = 8'h00;
    @(negedge clk);
    in_x = 8'h08;
    @(negedge clk);
    in_x      = 8'hF8;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold%0d_y", k), 32'(out_y), 32'd8);
      check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    got_q.delete();
    cyc = 0;
    while (got_q.size() < 3 && cyc < 20) begin
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got_q.push_back(out_y);
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    check("bp_count", 32'(got_q.size()), 32'd3);
    while (got_q.size() < 3) got_q.push_back(8'hXX);
    check("bp_order0", 32'(got_q[0]), 32'd8);
    check("bp_order1", 32'(got_q[1]), 32'd9);
    check("bp_order2", 32'(got_q[2]), 32'd6);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("bp_extra", 32'(out_valid), 32'd0);

    // Reset with two samples in flight.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 8'h00;
    @(negedge clk);
    in_x = 8'h08;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("rstmid_pre_valid", 32'(out_valid), 32'd1);
    check("rstmid_pre_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_out_y", 32'(out_y), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("rstmid_stale%0d", k), 32'(out_valid), 32'd0);
    end

    // Random stream with random valid/ready against the reference model.
    exp_q.delete();
    sent       = 0;
    got        = 0;
    cyc        = 0;
    acc        = 1'b0;
    prev_stall = 1'b0;
    prev_y     = 8'h00;
    in_valid   = 1'b0;
    while (got < NRAND && cyc < 60000) begin
      @(negedge clk);
      if (!in_valid || acc) begin
        if (sent < NRAND && $urandom_range(3) != 0) begin
          in_valid = 1'b1;
          in_x     = 8'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (prev_stall) begin
        check("rnd_hold_valid", 32'(out_valid), 32'd1);
        check("rnd_hold_y", 32'(out_y), 32'(prev_y));
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(8'(model(in_x)));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_output", 32'(out_y), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rnd%0d_y", got), 32'(out_y), 32'(e));
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      cyc++;
    end
    check("rnd_received", 32'(got), 32'(NRAND));
    check("rnd_leftover", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
